// File: rtl/uart_rx_monitor.sv
// ---------------------------------------------------------------------------
// uart_rx_monitor
//
// Receive-side UART stage for the SoC console line (pad_uart_tx). It
// deserialises 8N1 frames, buffers good bytes in a small FIFO and offers them
// on a valid/ready stream. It also reports framing errors and FIFO overflow.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   rx_i         serial input, idle high
//   data_o       head-of-FIFO byte (registered)
//   valid_o      FIFO non-empty
//   ready_i      consumer accepts data_o when valid_o & ready_i
//   frame_err_o  one-cycle pulse when the stop bit is sampled low
//   overflow_o   sticky flag: a good byte was dropped because the FIFO was full
//   clear_i      synchronous clear of overflow_o (a new overflow wins)
//   busy_o       high while the receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_monitor #(
  parameter int unsigned CLKS_PER_BIT = 1085,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  input  logic       clear_i,
  output logic       busy_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // Input synchroniser. Both flops reset to the idle (high) line level so a
  // reset never looks like a start edge.
  // -------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Receiver FSM
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push;
  logic             frame_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_err = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      // Re-check the line half a bit after the falling edge; a high line here
      // means the edge was a glitch and nothing is received.
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // From the start-bit midpoint, a full bit period lands on the middle
      // of each data bit. LSB arrives first.
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            push = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output FIFO. Pointers carry one extra wrap bit to tell full from empty.
  // -------------------------------------------------------------------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  data_q, data_d;
  logic        overflow_q, overflow_d;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        ovf_evt;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so a push into a full FIFO that is
  // being drained is still accepted.
  assign pop     = !empty && ready_i;
  assign push_ok = push && (!full || pop);
  assign ovf_evt = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW + 1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);

    // data_o is loaded from the entry the read pointer will address next.
    // The byte being written this cycle is not in memory yet, so forward it
    // when it is that entry.
    if (wr_ptr_d == rd_ptr_d) begin
      data_d = '0;
    end else if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      data_d = shift_q;
    end else begin
      data_d = mem_q[rd_ptr_d[AW-1:0]];
    end

    if (ovf_evt) begin
      overflow_d = 1'b1;
    end else if (clear_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = !empty;
  assign frame_err_o = frame_err;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q != IDLE);

endmodule
